// File: rtl/mem_access_pkg.sv
// Shared codes for the data-memory access controller: access sizes, FSM state
// encodings, latched request fields and alignment helpers.
package mem_access_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef struct packed {
        logic       write;
        logic [1:0] size;
        logic       zext;
    } req_ctl_t;

    // The reserved size code 2'b11 behaves as a full word.
    function automatic logic is_word(input logic [1:0] size);
        return (size == SIZE_W) || (size == 2'b11);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SIZE_H) && lo[0]) || (is_word(size) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts and extends load data from a memory word and
// merges store data into the addressed byte/half lane for read-modify-write.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    localparam bit BE = (BIG_ENDIAN != 0);

    logic [4:0]  shift;
    logic [31:0] shifted;

    // Byte/half lanes are brought down to bit 0 and then sign- or zero-extended.
    always_comb begin
        shift = 5'd0;
        case (size)
            SIZE_B:  shift = BE ? {~addr_lo, 3'b000} : {addr_lo, 3'b000};
            SIZE_H:  shift = BE ? {~addr_lo[1], 4'b0000} : {addr_lo[1], 4'b0000};
            default: shift = 5'd0;
        endcase
        shifted = word >> shift;
        case (size)
            SIZE_B:  load_data = {{24{shifted[7] & ~zext}}, shifted[7:0]};
            SIZE_H:  load_data = {{16{shifted[15] & ~zext}}, shifted[15:0]};
            default: load_data = word;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // K is the byte index (address offset) that lives at bit position 8*gi.
            localparam logic [1:0] K = 2'(BE ? (3 - gi) : gi);
            logic       sel;
            logic [7:0] src;
            always_comb begin
                sel = 1'b1;
                src = wdata[8*gi +: 8];
                case (size)
                    SIZE_B: begin
                        sel = (addr_lo == K);
                        src = wdata[7:0];
                    end
                    SIZE_H: begin
                        sel = (addr_lo[1] == K[1]);
                        src = (K[0] ^ BE) ? wdata[15:8] : wdata[7:0];
                    end
                    default: ;
                endcase
            end
            assign store_word[8*gi +: 8] = sel ? src : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a word-wide data memory; sub-word stores use read-modify-write.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses respond with resp_err, no memory cycle.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       writeData,
    input  logic [31:0]       readdata
);

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] addr_reg;
    req_ctl_t          ctl_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       word_reg;
    logic [31:0]       rdata_reg;
    logic [31:0]       align_word;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    // Loads extract straight from readdata; stores merge into the word captured in RD.
    assign align_word = (state_reg == ST_RD) ? readdata : word_reg;

    mem_lane_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_align (
        .word      (align_word),
        .addr_lo   (addr_reg[1:0]),
        .size      (ctl_reg.size),
        .zext      (ctl_reg.zext),
        .wdata     (wdata_reg),
        .load_data (load_data),
        .store_word(store_word)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    if (is_misaligned(req_size, req_addr[1:0]))
                        state_next = ST_RESP;
                    else
`endif
                    if (req_write && is_word(req_size))
                        state_next = ST_WR;
                    else
                        state_next = ST_RD;
                end
            end
            ST_RD:   state_next = ctl_reg.write ? ST_WR : ST_RESP;
            ST_WR:   state_next = ST_RESP;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            ctl_reg   <= '0;
            wdata_reg <= '0;
            word_reg  <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && req_valid) begin
                addr_reg  <= req_addr;
                ctl_reg   <= '{write: req_write, size: req_size, zext: req_unsigned};
                wdata_reg <= req_wdata;
            end
            if (state_reg == ST_RD)
                word_reg <= readdata;
            // resp_rdata only changes on the way into RESP, so it holds between responses.
            if ((state_next == ST_RESP) && (state_reg != ST_RESP))
                rdata_reg <= (state_reg == ST_RD) ? load_data : 32'd0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic err_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_reg <= 1'b0;
        else if ((state_next == ST_RESP) && (state_reg != ST_RESP))
            err_reg <= (state_reg == ST_IDLE);
    end
    assign resp_err = err_reg;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = (state_reg == ST_IDLE);
    assign resp_valid = (state_reg == ST_RESP);
    assign resp_rdata = rdata_reg;
    assign memread    = (state_reg == ST_RD);
    assign memwrite   = (state_reg == ST_WR);
    assign address    = {addr_reg[ADDR_W-1:2], 2'b00};
    assign writeData  = memwrite ? store_word : 32'd0;

endmodule
